// File: rtl/graphics_engine.sv
// graphics_engine: rectangle fill / clear / Bresenham line rasteriser writing one VRAM pixel per cycle.
// Define GFX_LINE_EN to build the LINE command; without it LINE behaves as NOP.
module graphics_engine #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int COLOR_W = 12,
  localparam int X_W = $clog2(H_RES),
  localparam int Y_W = $clog2(V_RES),
  localparam int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [COLOR_W-1:0] vram_data,
  output logic               busy,
  output logic               done
);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DONE = 2'd3;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);
  logic [1:0] state_q, state_d;
  logic [X_W-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d, px, cx0, cx1, fx0, fx1;
  logic [Y_W-1:0] y_q, y_d, y1_q, y1_d, py, cy0, cy1, fy0, fy1;
  logic [COLOR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, emit, fill_ok;
  assign cx0 = cmd_x0 > X_MAX ? X_MAX : cmd_x0;
  assign cx1 = cmd_x1 > X_MAX ? X_MAX : cmd_x1;
  assign cy0 = cmd_y0 > Y_MAX ? Y_MAX : cmd_y0;
  assign cy1 = cmd_y1 > Y_MAX ? Y_MAX : cmd_y1;
  assign fx0 = cmd_op == 2'd2 ? '0 : cx0;
  assign fx1 = cmd_op == 2'd2 ? X_MAX : cx1;
  assign fy0 = cmd_op == 2'd2 ? '0 : cy0;
  assign fy1 = cmd_op == 2'd2 ? Y_MAX : cy1;
  assign fill_ok = (cmd_op == 2'd0 || cmd_op == 2'd2) && fx0 <= fx1 && fy0 <= fy1;
`ifdef GFX_LINE_EN
  localparam logic [1:0] LINE = 2'd2;
  localparam int E = (X_W > Y_W ? X_W : Y_W) + 2;
  logic signed [E-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d, ldx, ldy, e2, nerr;
  logic sxn_q, sxn_d, syn_q, syn_d, stepx, stepy;
  logic [X_W-1:0] dxa, lx;
  logic [Y_W-1:0] dya, ly;
  assign dxa = cx1 >= cx0 ? cx1 - cx0 : cx0 - cx1;
  assign dya = cy1 >= cy0 ? cy1 - cy0 : cy0 - cy1;
  assign ldx = $signed(E'(dxa));
  assign ldy = -$signed(E'(dya));
  assign e2 = err_q <<< 1;
  assign stepx = e2 >= dy_q;
  assign stepy = e2 <= dx_q;
  assign nerr = err_q + (stepx ? dy_q : '0) + (stepy ? dx_q : '0);
  assign lx = stepx ? (sxn_q ? x_q - X_W'(1) : x_q + X_W'(1)) : x_q;
  assign ly = stepy ? (syn_q ? y_q - Y_W'(1) : y_q + Y_W'(1)) : y_q;
`endif
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    data_d = data_q;
    emit = 1'b0;
    px = x_q;
    py = y_q;
`ifdef GFX_LINE_EN
    err_d = err_q;
    dx_d = dx_q;
    dy_d = dy_q;
    sxn_d = sxn_q;
    syn_d = syn_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        // Empty commands pass through FILL with no write so done lands two cycles after acceptance
        state_d = FILL;
        data_d = cmd_color;
        if (fill_ok) begin
          emit = 1'b1;
          px = fx0;
          py = fy0;
          x_d = fx0;
          y_d = fy0;
          x0_d = fx0;
          x1_d = fx1;
          y1_d = fy1;
        end
`ifdef GFX_LINE_EN
        if (cmd_op == 2'd1) begin
          state_d = LINE;
          emit = 1'b1;
          px = cx0;
          py = cy0;
          x_d = cx0;
          y_d = cy0;
          x1_d = cx1;
          y1_d = cy1;
          dx_d = ldx;
          dy_d = ldy;
          err_d = ldx + ldy;
          sxn_d = cx1 < cx0;
          syn_d = cy1 < cy0;
        end
`endif
      end
      FILL: if (abort) state_d = IDLE;
      else if (!we_q || (x_q == x1_q && y_q == y1_q)) state_d = DONE;
      else begin
        emit = 1'b1;
        px = x_q == x1_q ? x0_q : x_q + X_W'(1);
        py = x_q == x1_q ? y_q + Y_W'(1) : y_q;
        x_d = px;
        y_d = py;
      end
`ifdef GFX_LINE_EN
      LINE: if (abort) state_d = IDLE;
      else if (x_q == x1_q && y_q == y1_q) state_d = DONE;
      else begin
        emit = 1'b1;
        px = lx;
        py = ly;
        x_d = lx;
        y_d = ly;
        err_d = nerr;
      end
`endif
      default: state_d = IDLE;
    endcase
    addr_d = emit ? ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px) : addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
`ifdef GFX_LINE_EN
      err_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      sxn_q <= 1'b0;
      syn_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      data_q <= data_d;
      addr_q <= addr_d;
      we_q <= emit;
`ifdef GFX_LINE_EN
      err_q <= err_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      sxn_q <= sxn_d;
      syn_q <= syn_d;
`endif
    end
  end
  assign cmd_ready = rst_n && state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE && !abort;
  assign vram_we = we_q;
  assign vram_addr = addr_q;
  assign vram_data = data_q;
endmodule

// File: tb/tb_graphics_engine.sv
// tb_graphics_engine: directed scoreboard bench for graphics_engine (640x480 main instance, 20x10 instance for CLEAR).
module tb_graphics_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, abort = 1'b0;
  logic [1:0] cmd_op = 2'd3;
  logic [9:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [8:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic cmd_ready, vram_we, busy, done;
  logic [18:0] vram_addr;
  logic [11:0] vram_data;
  logic s_valid = 1'b0, s_abort = 1'b0;
  logic [1:0] s_op = 2'd3;
  logic [4:0] s_x0 = 5'd3, s_x1 = 5'd1;
  logic [3:0] s_y0 = 4'd2, s_y1 = 4'd1;
  logic [11:0] s_color = '0;
  logic s_ready, s_we, s_busy, s_done;
  logic [7:0] s_addr;
  logic [11:0] s_data;
  int checks = 0, errors = 0;
  int q[$];

  graphics_engine dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .abort(abort), .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
    .busy(busy), .done(done)
  );

  graphics_engine #(.H_RES(20), .V_RES(10), .COLOR_W(12)) u_small (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_op(s_op),
    .cmd_x0(s_x0), .cmd_x1(s_x1), .cmd_y0(s_y0), .cmd_y1(s_y1), .cmd_color(s_color),
    .abort(s_abort), .vram_we(s_we), .vram_addr(s_addr), .vram_data(s_data),
    .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int x0, input int y0, input int x1, input int y1,
                       input logic [11:0] col, input logic ab, input string tag);
    logic [31:0] vx0, vx1, vy0, vy1;
    vx0 = x0; vx1 = x1; vy0 = y0; vy1 = y1;
    @(negedge clk);
    cmd_op = op; cmd_x0 = vx0[9:0]; cmd_x1 = vx1[9:0]; cmd_y0 = vy0[8:0]; cmd_y1 = vy1[8:0];
    cmd_color = col; cmd_valid = 1'b1; abort = ab;
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; abort = 1'b0; cmd_op = ~op; cmd_color = ~col;
    cmd_x0 = ~cmd_x0; cmd_x1 = ~cmd_x1; cmd_y0 = ~cmd_y0; cmd_y1 = ~cmd_y1;
  endtask

  task automatic run(input logic [1:0] op, input int x0, input int y0, input int x1, input int y1,
                     input logic [11:0] col, input logic ab, input int nexp, input int done_at, input string tag);
    int nw, dn, fw, e;
    nw = 0; dn = 0; fw = 0;
    issue(op, x0, y0, x1, y1, col, ab, tag);
    for (int n = 1; n <= nexp + 10 && dn == 0; n++) begin
      @(negedge clk);
      if (vram_we) begin
        nw++;
        if (fw == 0) fw = n;
        chk({tag, " sb nonempty"}, 32'(q.size() > 0), 32'd1);
        e = q.size() > 0 ? q.pop_front() : -1;
        chk({tag, " addr"}, 32'(vram_addr), e);
        chk({tag, " data"}, 32'(vram_data), 32'(col));
        chk({tag, " busy"}, 32'(busy), 32'd1);
      end
      if (done) dn = n;
    end
    chk({tag, " writes"}, nw, nexp);
    chk({tag, " done cycle"}, dn, done_at);
    if (nexp > 0) chk({tag, " first write"}, fw, 1);
    chk({tag, " sb drained"}, q.size(), 0);
    q.delete();
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " ready after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int nw, dn, last, nd;
    #3;
    chk("reset we", 32'(vram_we), 0);
    chk("reset addr", 32'(vram_addr), 0);
    chk("reset data", 32'(vram_data), 0);
    chk("reset done", 32'(done), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset ready", 32'(cmd_ready), 1);

    q.push_back(1922); q.push_back(1923); q.push_back(1924);
    q.push_back(2562); q.push_back(2563); q.push_back(2564);
    run(2'd0, 2, 3, 4, 4, 12'hF00, 1'b0, 6, 7, "fill6");

`ifdef GFX_LINE_EN
    q.push_back(0); q.push_back(1); q.push_back(642); q.push_back(643);
    run(2'd1, 0, 0, 3, 1, 12'h0F0, 1'b0, 4, 5, "line");
    q.push_back(1282); q.push_back(642); q.push_back(2);
    run(2'd1, 2, 2, 2, 0, 12'h00F, 1'b0, 3, 4, "line vert");
    q.push_back(5*640+7);
    run(2'd1, 7, 5, 7, 5, 12'h111, 1'b0, 1, 2, "line point");
`else
    run(2'd1, 0, 0, 3, 1, 12'h0F0, 1'b0, 0, 2, "line off");
`endif

    run(2'd0, 5, 0, 4, 0, 12'hABC, 1'b0, 0, 2, "fill empty");
    run(2'd3, 1, 1, 5, 5, 12'hABC, 1'b0, 0, 2, "nop");

    for (int x = 630; x <= 639; x++) q.push_back(479 * 640 + x);
    run(2'd0, 630, 479, 700, 500, 12'h5A5, 1'b0, 10, 11, "clamp");

    q.push_back(641); q.push_back(642);
    run(2'd0, 1, 1, 2, 1, 12'h777, 1'b1, 2, 3, "abort in idle");

    issue(2'd0, 0, 0, 9, 0, 12'h321, 1'b0, "abort fill");
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk("abort fill we", 32'(vram_we), 1);
      chk("abort fill addr", 32'(vram_addr), n - 1);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort we", 32'(vram_we), 0);
    chk("abort ready", 32'(cmd_ready), 1);
    chk("abort busy", 32'(busy), 0);
    nw = 0; nd = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      nw += int'(vram_we);
      nd += int'(done);
    end
    chk("abort no writes after", nw, 0);
    chk("abort no done", nd, 0);

`ifdef GFX_LINE_EN
    issue(2'd1, 0, 0, 9, 3, 12'h456, 1'b0, "reset mid");
`else
    issue(2'd0, 0, 0, 9, 0, 12'h456, 1'b0, "reset mid");
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset mid we before", 32'(vram_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset mid we", 32'(vram_we), 0);
    chk("reset mid busy", 32'(busy), 0);
    chk("reset mid ready", 32'(cmd_ready), 0);
    chk("reset mid addr", 32'(vram_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) chk("reset mid ready after", 32'(cmd_ready), 1);
      nd += int'(done) + int'(vram_we);
    end
    chk("reset mid no done", nd, 0);

    @(negedge clk);
    s_op = 2'd2; s_color = 12'h123; s_valid = 1'b1;
    chk("clear ready", 32'(s_ready), 1);
    @(posedge clk);
    #1 s_valid = 1'b0; s_color = 12'hFFF; s_op = 2'd3;
    nw = 0; dn = 0; last = -1; nd = 0;
    for (int n = 1; n <= 240; n++) begin
      @(negedge clk);
      if (s_we) begin
        chk("clear addr", 32'(s_addr), nw);
        chk("clear data", 32'(s_data), 32'h123);
        last = int'(s_addr);
        nw++;
      end
      if (s_done) begin
        nd++;
        if (dn == 0) dn = n;
      end
    end
    chk("clear writes", nw, 200);
    chk("clear last addr", last, 199);
    chk("clear done cycle", dn, 201);
    chk("clear done once", nd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
